// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Per-channel two-flop synchroniser and counter-based debouncer for
//            push-button / switch pins, with registered press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1, so it can never wrap.
    localparam int              c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    // Idle (not pressed) pin level; also the reset value of every level flop.
    localparam logic            c_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic               r_sync1_q;
        logic               r_sync2_q;
        state_t             r_state_q;
        state_t             w_state_d;
        logic [c_CNT_W-1:0] r_cnt_q;
        logic [c_CNT_W-1:0] w_cnt_d;
        logic               r_stable_q;
        logic               w_stable_d;
        logic               r_press_q;
        logic               w_press_d;
        logic               r_release_q;
        logic               w_release_d;

        // Qualify a level change: it must persist for DEBOUNCE_CYCLES
        // consecutive synchronised samples, any bounce restarts the count.
        always_comb begin
            w_state_d  = r_state_q;
            w_cnt_d    = r_cnt_q;
            w_stable_d = r_stable_q;
            case (r_state_q)
                ST_IDLE: begin
                    if (r_sync2_q != r_stable_q) begin
                        w_cnt_d   = c_CNT_ONE;
                        w_state_d = ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (r_sync2_q == r_stable_q) begin
                        w_cnt_d   = '0;
                        w_state_d = ST_IDLE;
                    end else if (r_cnt_q == c_CNT_MAX) begin
                        w_stable_d = r_sync2_q;
                        w_cnt_d    = '0;
                        w_state_d  = ST_IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CNT_ONE;
                    end
                end
                default: begin
                    w_cnt_d   = '0;
                    w_state_d = ST_IDLE;
                end
            endcase
            // Strobes fire in the same cycle the accepted level appears.
            w_press_d   = (w_stable_d != r_stable_q) && (w_stable_d != c_RELEASED);
            w_release_d = (w_stable_d != r_stable_q) && (w_stable_d == c_RELEASED);
        end

        // Synchroniser, debounce state and registered strobes.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_sync1_q   <= c_RELEASED;
                r_sync2_q   <= c_RELEASED;
                r_state_q   <= ST_IDLE;
                r_cnt_q     <= '0;
                r_stable_q  <= c_RELEASED;
                r_press_q   <= 1'b0;
                r_release_q <= 1'b0;
            end else begin
                r_sync1_q   <= raw_in[i];
                r_sync2_q   <= r_sync1_q;
                r_state_q   <= w_state_d;
                r_cnt_q     <= w_cnt_d;
                r_stable_q  <= w_stable_d;
                r_press_q   <= w_press_d;
                r_release_q <= w_release_d;
            end
        end

        assign debounced_out[i] = r_stable_q;
        assign press_pulse[i]   = r_press_q;
        assign release_pulse[i] = r_release_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Brief    : Self-checking bench for button_debounce (WIDTH=4, DEBOUNCE_CYCLES=4,
//            ACTIVE_LOW=1): directed vector table, hand-written corner cases and
//            randomized stimulus against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int c_W  = 4;
    localparam int c_DC = 4;

    logic           clk_clk = 1'b0;
    logic           reset_reset_n;
    logic [c_W-1:0] raw_in;
    logic [c_W-1:0] debounced_out;
    logic [c_W-1:0] press_pulse;
    logic [c_W-1:0] release_pulse;

    button_debounce #(
        .WIDTH          (c_W),
        .DEBOUNCE_CYCLES(c_DC),
        .ACTIVE_LOW     (1)
    ) u_dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .raw_in       (raw_in),
        .debounced_out(debounced_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk_clk = ~clk_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a pin level is accepted once the synchronised value
    // (raw delayed by two edges) has disagreed with the accepted level on
    // DEBOUNCE_CYCLES consecutive edges.
    logic [c_W-1:0] m_s1, m_s2, m_stable, m_press, m_rel;
    int             m_run [c_W];

    task automatic model_reset();
        m_s1     = '1;
        m_s2     = '1;
        m_stable = '1;
        m_press  = '0;
        m_rel    = '0;
        for (int c = 0; c < c_W; c++) m_run[c] = 0;
    endtask

    task automatic model_edge();
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < c_W; c++) begin
            if (m_s2[c] != m_stable[c]) begin
                m_run[c]++;
                if (m_run[c] == c_DC) begin
                    m_stable[c] = m_s2[c];
                    m_run[c]    = 0;
                    if (m_stable[c] == 1'b0) m_press[c] = 1'b1;
                    else                     m_rel[c]   = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw_in;
    endtask

    // One rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_clk);
        if (reset_reset_n) model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [c_W-1:0] eo,
                             input logic [c_W-1:0] ep, input logic [c_W-1:0] er);
        check({name, ".out"},     debounced_out, eo);
        check({name, ".press"},   press_pulse,   ep);
        check({name, ".release"}, release_pulse, er);
    endtask

    typedef struct {
        logic [c_W-1:0] raw;
        logic [c_W-1:0] out;
        logic [c_W-1:0] prs;
        logic [c_W-1:0] rel;
    } vec_t;

    vec_t tbl [27];

    initial begin
        logic [c_W-1:0] rv;
        int             hold [c_W];

        // Each entry: drive raw, one edge, then expect these outputs.
        // A change driven before edge 1 is accepted on edge 6.
        tbl[0]  = '{4'hE, 4'hF, 4'h0, 4'h0};
        tbl[1]  = '{4'hE, 4'hF, 4'h0, 4'h0};
        tbl[2]  = '{4'hE, 4'hF, 4'h0, 4'h0};
        tbl[3]  = '{4'hE, 4'hF, 4'h0, 4'h0};
        tbl[4]  = '{4'hE, 4'hF, 4'h0, 4'h0};
        tbl[5]  = '{4'hE, 4'hE, 4'h1, 4'h0};
        tbl[6]  = '{4'hE, 4'hE, 4'h0, 4'h0};
        tbl[7]  = '{4'hF, 4'hE, 4'h0, 4'h0};
        tbl[8]  = '{4'hF, 4'hE, 4'h0, 4'h0};
        tbl[9]  = '{4'hF, 4'hE, 4'h0, 4'h0};
        tbl[10] = '{4'hF, 4'hE, 4'h0, 4'h0};
        tbl[11] = '{4'hF, 4'hE, 4'h0, 4'h0};
        tbl[12] = '{4'hF, 4'hF, 4'h0, 4'h1};
        tbl[13] = '{4'hF, 4'hF, 4'h0, 4'h0};
        tbl[14] = '{4'h0, 4'hF, 4'h0, 4'h0};
        tbl[15] = '{4'h0, 4'hF, 4'h0, 4'h0};
        tbl[16] = '{4'h0, 4'hF, 4'h0, 4'h0};
        tbl[17] = '{4'h0, 4'hF, 4'h0, 4'h0};
        tbl[18] = '{4'h0, 4'hF, 4'h0, 4'h0};
        tbl[19] = '{4'h0, 4'h0, 4'hF, 4'h0};
        tbl[20] = '{4'hF, 4'h0, 4'h0, 4'h0};
        tbl[21] = '{4'hF, 4'h0, 4'h0, 4'h0};
        tbl[22] = '{4'hF, 4'h0, 4'h0, 4'h0};
        tbl[23] = '{4'hF, 4'h0, 4'h0, 4'h0};
        tbl[24] = '{4'hF, 4'h0, 4'h0, 4'h0};
        tbl[25] = '{4'hF, 4'hF, 4'h0, 4'hF};
        tbl[26] = '{4'hF, 4'hF, 4'h0, 4'h0};

        // Reset state
        reset_reset_n = 1'b0;
        raw_in        = 4'hF;
        model_reset();
        repeat (3) tick();
        check_all("reset", 4'hF, 4'h0, 4'h0);
        reset_reset_n = 1'b1;

        // Idle, all released
        for (int k = 0; k < 20; k++) begin
            tick();
            check_all("idle", 4'hF, 4'h0, 4'h0);
        end

        // Directed vector table: single-channel press/release, all-channel press/release
        for (int k = 0; k < 27; k++) begin
            raw_in = tbl[k].raw;
            tick();
            check_all($sformatf("vec%0d", k), tbl[k].out, tbl[k].prs, tbl[k].rel);
        end

        // Bounce on channel 1: low for only 3 cycles at a time, never accepted
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                raw_in = (k == 3) ? 4'hF : 4'hD;
                tick();
                check_all("bounce", 4'hF, 4'h0, 4'h0);
            end
        end

        // Reset in the middle of qualification on channel 2
        raw_in = 4'hB;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all("prereset", 4'hF, 4'h0, 4'h0);
        end
        reset_reset_n = 1'b0;
        model_reset();
        #1;
        check_all("inreset", 4'hF, 4'h0, 4'h0);
        repeat (2) tick();
        check_all("inreset2", 4'hF, 4'h0, 4'h0);
        reset_reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("postreset_wait", 4'hF, 4'h0, 4'h0);
        end
        tick();
        check_all("postreset_accept", 4'hB, 4'h4, 4'h0);
        tick();
        check_all("postreset_hold", 4'hB, 4'h0, 4'h0);

        // Randomized hold lengths around the debounce window vs. model
        rv = raw_in;
        for (int c = 0; c < c_W; c++) hold[c] = 0;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < c_W; c++) begin
                if (hold[c] == 0) begin
                    rv[c]   = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 9));
                end else begin
                    hold[c]--;
                end
            end
            raw_in = rv;
            tick();
            check_all("rand", m_stable, m_press, m_rel);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
